// File: rtl/sharpen_sequencer.sv
// 3x3 sharpen job controller: config registers, per-pixel 9-tap fetch, MAC strobe and result write.
// Latency: START->first mem_req 2 cycles, 12 cycles/pixel with zero-wait memory; stalls while mem_ack is low.
// Optional SHARP_PERF_CNT_EN adds saturating CYCLES (reg 6) and STALLS (reg 7) counters.
module sharpen_sequencer #(
  parameter int AW = 16,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [4:0]    cfg_addr,
  input  logic [31:0]   cfg_wdata,
  output logic [31:0]   cfg_rdata,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  output logic          win_valid,
  output logic [3:0]    win_idx,
  output logic          mac_go,
  output logic          busy,
  output logic          done_irq
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_FETCH, S_MAC, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] width_q, height_q;
  logic [AW-1:0] src_q, dst_q;
  logic [DW-1:0] row_q, col_q, row_nxt, col_nxt;
  logic [3:0]    tap_q, tap_nxt;
  logic          done_q, err_q, done_nxt, err_nxt;
  logic          req_nxt, wr_nxt;
  logic [AW-1:0] addr_nxt;
  logic          start_wr, clr_wr, acked;
  logic [1:0]    dy, dx;
  logic [AW-1:0] row_a, col_a, width_a, rd_line, rd_prod, wr_prod, rd_addr, wr_addr;

  assign start_wr  = cfg_we && (cfg_addr == 5'd0) && cfg_wdata[0];
  assign clr_wr    = cfg_we && (cfg_addr == 5'd0) && cfg_wdata[1];
  assign acked     = mem_req && mem_ack;
  assign busy      = (state == S_CHECK) || (state == S_FETCH) || (state == S_MAC) ||
                     (state == S_WRITE) || (state == S_NEXT);
  assign win_valid = mem_req && !mem_wr && mem_ack;
  assign win_idx   = (state == S_FETCH) ? tap_q : 4'd0;
  assign mac_go    = (state == S_MAC);
  assign done_irq  = done_q;

  always_comb begin
    state_nxt = state;
    row_nxt   = row_q;
    col_nxt   = col_q;
    tap_nxt   = tap_q;
    done_nxt  = done_q;
    err_nxt   = err_q;
    case (state)
      S_IDLE: begin
        if (start_wr) begin
          state_nxt = S_CHECK;
          done_nxt  = 1'b0;
          err_nxt   = 1'b0;
        end else if (clr_wr) begin
          done_nxt = 1'b0;
        end
      end
      S_CHECK: begin
        if ((width_q < DW'(3)) || (height_q < DW'(3))) begin
          err_nxt   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          row_nxt   = DW'(1);
          col_nxt   = DW'(1);
          tap_nxt   = 4'd0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (acked) begin
          if (tap_q == 4'd8) state_nxt = S_MAC;
          else               tap_nxt   = tap_q + 4'd1;
        end
      end
      S_MAC: state_nxt = S_WRITE;
      S_WRITE: begin
        if (acked) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        tap_nxt = 4'd0;
        if (col_q == width_q - DW'(2)) begin
          col_nxt = DW'(1);
          row_nxt = row_q + DW'(1);
          if (row_q == height_q - DW'(2)) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_FETCH;
          end
        end else begin
          col_nxt   = col_q + DW'(1);
          state_nxt = S_FETCH;
        end
      end
      S_DONE: begin
        // START has priority over CLR_DONE when both bits are written together
        if (start_wr) begin
          state_nxt = S_CHECK;
          done_nxt  = 1'b0;
          err_nxt   = 1'b0;
        end else if (clr_wr) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dy = 2'd0;
    dx = 2'd0;
    case (tap_nxt)
      4'd1: dx = 2'd1;
      4'd2: dx = 2'd2;
      4'd3: dy = 2'd1;
      4'd4: begin dy = 2'd1; dx = 2'd1; end
      4'd5: begin dy = 2'd1; dx = 2'd2; end
      4'd6: dy = 2'd2;
      4'd7: begin dy = 2'd2; dx = 2'd1; end
      4'd8: begin dy = 2'd2; dx = 2'd2; end
      default: begin dy = 2'd0; dx = 2'd0; end
    endcase
  end

  // Addresses are built from next-cycle counters so mem_addr can be registered
  always_comb begin
    row_a    = AW'(row_nxt);
    col_a    = AW'(col_nxt);
    width_a  = AW'(width_q);
    rd_line  = row_a + AW'(dy) - AW'(1);
    rd_prod  = rd_line * width_a;
    wr_prod  = row_a * width_a;
    rd_addr  = src_q + rd_prod + col_a + AW'(dx) - AW'(1);
    wr_addr  = dst_q + wr_prod + col_a;
    req_nxt  = (state_nxt == S_FETCH) || (state_nxt == S_WRITE);
    wr_nxt   = (state_nxt == S_WRITE);
    addr_nxt = mem_addr;
    if (req_nxt) addr_nxt = wr_nxt ? wr_addr : rd_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      tap_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mem_req  <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_nxt;
      row_q    <= row_nxt;
      col_q    <= col_nxt;
      tap_q    <= tap_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
      mem_req  <= req_nxt;
      mem_wr   <= wr_nxt;
      mem_addr <= addr_nxt;
    end
  end

  // Geometry and base addresses are frozen for the duration of a job
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width_q  <= '0;
      height_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
    end else if (cfg_we && !busy) begin
      case (cfg_addr)
        5'd1: width_q  <= cfg_wdata[DW-1:0];
        5'd2: height_q <= cfg_wdata[DW-1:0];
        5'd3: src_q    <= cfg_wdata[AW-1:0];
        5'd4: dst_q    <= cfg_wdata[AW-1:0];
        default: ;
      endcase
    end
  end

`ifdef SHARP_PERF_CNT_EN
  logic [31:0] cycles_q, stalls_q;
  logic        start_acc;

  assign start_acc = start_wr && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles_q <= '0;
      stalls_q <= '0;
    end else if (start_acc) begin
      cycles_q <= '0;
      stalls_q <= '0;
    end else begin
      if (busy && (cycles_q != 32'hFFFF_FFFF))
        cycles_q <= cycles_q + 32'd1;
      if (mem_req && !mem_ack && (stalls_q != 32'hFFFF_FFFF))
        stalls_q <= stalls_q + 32'd1;
    end
  end
`endif

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      5'd1: cfg_rdata = 32'(width_q);
      5'd2: cfg_rdata = 32'(height_q);
      5'd3: cfg_rdata = 32'(src_q);
      5'd4: cfg_rdata = 32'(dst_q);
      5'd5: cfg_rdata = {29'd0, err_q, done_q, busy};
`ifdef SHARP_PERF_CNT_EN
      5'd6: cfg_rdata = cycles_q;
      5'd7: cfg_rdata = stalls_q;
`endif
      default: cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_sharpen_sequencer.sv
// Bench for sharpen_sequencer: register vector table, access scoreboard, job-level corner sequences.
module tb_sharpen_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic        win_valid;
  logic [3:0]  win_idx;
  logic        mac_go, busy, done_irq;

  sharpen_sequencer dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .mem_req(mem_req),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .win_valid(win_valid), .win_idx(win_idx), .mac_go(mac_go),
    .busy(busy), .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [3:0]  idx;
  } acc_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  acc_t sb[$];
  int   n_cmp = 0, n_bad = 0;
  int   rd_cnt = 0, wr_cnt = 0, mac_cnt = 0;
  int   ack_delay = 0, wait_cnt = 0;
  logic ack_tie = 1'b0;
  logic prev_req = 1'b0, prev_ack = 1'b0;
  logic stall_prev = 1'b0, stall_wr = 1'b0;
  logic [15:0] stall_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Memory responder: tie-high or ack after ack_delay wait cycles per access
  always @(negedge clk) begin
    prev_req = mem_req;
    prev_ack = mem_ack;
  end
  always @(posedge clk) begin
    #1;
    if (!prev_req || prev_ack) wait_cnt = 0;
    else wait_cnt++;
    mem_ack = ack_tie ? 1'b1 : (mem_req && (wait_cnt >= ack_delay));
  end

  // Access monitor / scoreboard consumer
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && mem_req) begin
        chk("stall addr stable", 32'(mem_addr), 32'(stall_addr));
        chk("stall wr stable", 32'(mem_wr), 32'(stall_wr));
      end
      stall_prev = mem_req && !mem_ack;
      stall_addr = mem_addr;
      stall_wr   = mem_wr;
      if (mac_go) mac_cnt++;
      if (mem_req && mem_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected access", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          acc_t e;
          e = sb.pop_front();
          chk("acc wr", 32'(mem_wr), 32'(e.wr));
          chk("acc addr", 32'(mem_addr), 32'(e.addr));
          chk("acc win_idx", 32'(win_idx), 32'(e.idx));
          chk("acc win_valid", 32'(win_valid), 32'(!e.wr));
          if (e.wr) wr_cnt++;
          else rd_cnt++;
        end
      end
    end
  end

  task automatic push_job(input int w, input int h, input int src, input int dst);
    acc_t e;
    for (int r = 1; r <= h - 2; r++) begin
      for (int c = 1; c <= w - 2; c++) begin
        for (int t = 0; t < 9; t++) begin
          e.wr   = 1'b0;
          e.addr = 16'(src + (r + t / 3 - 1) * w + (c + t % 3 - 1));
          e.idx  = 4'(t);
          sb.push_back(e);
        end
        e.wr   = 1'b1;
        e.addr = 16'(dst + r * w + c);
        e.idx  = 4'd0;
        sb.push_back(e);
      end
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic start_job(input int w, input int h, input int src, input int dst);
    write_reg(5'd1, 32'(w));
    write_reg(5'd2, 32'(h));
    write_reg(5'd3, 32'(src));
    write_reg(5'd4, 32'(dst));
    push_job(w, h, src, dst);
    write_reg(5'd0, 32'd1);
  endtask

  task automatic wait_done(input string nm, input int exp_n);
    int n = 0;
    while (!done_irq && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " done_irq"}, 32'(done_irq), 32'd1);
    if (exp_n >= 0) chk({nm, " latency"}, 32'(n), 32'(exp_n));
    chk({nm, " scoreboard empty"}, 32'(sb.size()), 32'd0);
  endtask

  vec_t        vt[11];
  logic [31:0] rd;

  initial begin
    vt[0]  = '{1'b1, 5'd1,  32'h0000_0123, 32'h0000_0123};
    vt[1]  = '{1'b1, 5'd1,  32'hFFFF_FFFF, 32'h0000_0FFF};
    vt[2]  = '{1'b1, 5'd2,  32'h0000_0ABC, 32'h0000_0ABC};
    vt[3]  = '{1'b1, 5'd3,  32'h0001_2345, 32'h0000_2345};
    vt[4]  = '{1'b1, 5'd4,  32'hDEAD_BEEF, 32'h0000_BEEF};
    vt[5]  = '{1'b1, 5'd5,  32'hFFFF_FFFF, 32'h0000_0000};
    vt[6]  = '{1'b1, 5'd6,  32'h0000_1234, 32'h0000_0000};
    vt[7]  = '{1'b1, 5'd7,  32'h0000_5678, 32'h0000_0000};
    vt[8]  = '{1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[9]  = '{1'b1, 5'd0,  32'h0000_0002, 32'h0000_0000};
    vt[10] = '{1'b0, 5'd1,  32'h0000_0000, 32'h0000_0FFF};

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done_irq", 32'(done_irq), 32'd0);
    for (int a = 0; a < 8; a++) begin
      read_reg(5'(a), rd);
      chk($sformatf("reset reg%0d", a), rd, 32'd0);
    end

    // Register table
    for (int i = 0; i < 11; i++) begin
      if (vt[i].we) write_reg(vt[i].addr, vt[i].wdata);
      read_reg(vt[i].addr, rd);
      chk($sformatf("vec%0d reg%0d", i, vt[i].addr), rd, vt[i].exp);
    end

    // 4x4 job, memory acks every request immediately
    ack_tie = 1'b1;
    rd_cnt = 0; wr_cnt = 0; mac_cnt = 0;
    start_job(4, 4, 32'h100, 32'h200);
    chk("4x4 CHECK busy", 32'(busy), 32'd1);
    chk("4x4 CHECK no req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    chk("4x4 first req", 32'(mem_req), 32'd1);
    chk("4x4 first addr", 32'(mem_addr), 32'h100);
    wait_done("4x4", 48);
    chk("4x4 reads", 32'(rd_cnt), 32'd36);
    chk("4x4 writes", 32'(wr_cnt), 32'd4);
    chk("4x4 mac_go", 32'(mac_cnt), 32'd4);
    read_reg(5'd5, rd);
    chk("4x4 status", rd, 32'h2);

    // Degenerate geometry
    start_job(2, 5, 32'h40, 32'h80);
    read_reg(5'd5, rd);
    chk("err CHECK status", rd, 32'h1);
    @(posedge clk); #1;
    read_reg(5'd5, rd);
    chk("err status", rd, 32'h6);
    chk("err no req", 32'(mem_req), 32'd0);
    write_reg(5'd0, 32'd2);
    chk("err clr done_irq", 32'(done_irq), 32'd0);
    read_reg(5'd5, rd);
    chk("err clr status", rd, 32'h4);

    // Stalled memory
    ack_tie = 1'b0;
    ack_delay = 3;
    start_job(4, 4, 32'h100, 32'h200);
    wait_done("stall", -1);
`ifdef SHARP_PERF_CNT_EN
    read_reg(5'd7, rd);
    chk("stall STALLS", rd, 32'd120);
    read_reg(5'd6, rd);
    chk("stall CYCLES", rd, 32'd169);
`endif

    // Writes during a job are ignored
    ack_tie = 1'b1;
    ack_delay = 0;
    start_job(4, 4, 32'h300, 32'h3F0);
    repeat (10) @(posedge clk);
    write_reg(5'd1, 32'd9);
    write_reg(5'd0, 32'd1);
    chk("midjob busy", 32'(busy), 32'd1);
    wait_done("midjob", -1);
    read_reg(5'd1, rd);
    chk("midjob width kept", rd, 32'd4);

    // Asynchronous reset while a write is pending
    ack_tie = 1'b0;
    ack_delay = 3;
    start_job(4, 4, 32'h100, 32'h200);
    begin
      int n = 0;
      while (!(mem_req && mem_wr) && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("reach WRITE", 32'(mem_req && mem_wr), 32'd1);
    end
    #2 reset = 1'b1;
    #1;
    chk("async reset mem_req", 32'(mem_req), 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      read_reg(5'(a), rd);
      chk($sformatf("post-reset reg%0d", a), rd, 32'd0);
    end
    ack_tie = 1'b1;
    ack_delay = 0;
    start_job(5, 4, 32'hFFF0, 32'h0010);
    wait_done("5x4 wrap", -1);

    // CLR_DONE from DONE
    write_reg(5'd0, 32'd2);
    chk("clr done_irq", 32'(done_irq), 32'd0);
    read_reg(5'd5, rd);
    chk("clr status", rd, 32'd0);

    // START and CLR_DONE together from DONE restart the job
    start_job(3, 3, 32'h500, 32'h600);
    wait_done("3x3", 13);
    push_job(3, 3, 32'h500, 32'h600);
    write_reg(5'd0, 32'd3);
    chk("restart busy", 32'(busy), 32'd1);
    chk("restart done_irq", 32'(done_irq), 32'd0);
    wait_done("3x3 restart", 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sharpen_sequencer.md
# sharpen_sequencer

Job controller for the image-sharpening extension. It holds the job configuration written by the DLX through the slave register interface. For every interior pixel it fetches the 3x3 neighbourhood from image memory, strobes the sharpening datapath and issues the result write. It reports busy/done status back to the bus.

## Interface
Parameters:
- `AW`, 16: memory address width; all address registers and arithmetic are `AW` bits.
- `DW`, 12: width of the WIDTH/HEIGHT registers and of the row/col counters.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `cfg_we`  in  1  register write strobe from the bus slave, one cycle.
- `cfg_addr`  in  5  register address from the bus slave.
- `cfg_wdata`  in  32  register write data.
- `cfg_rdata`  out  32  combinational readback of the register at `cfg_addr`.
- `mem_req`  out  1  memory access request, held until acknowledged.
- `mem_wr`  out  1  qualifies `mem_req`: 1 = write, 0 = read.
- `mem_addr`  out  AW  access address, stable while `mem_req` is high.
- `mem_ack`  in  1  completes the current access in the same cycle.
- `win_valid`  out  1  `mem_req & ~mem_wr & mem_ack`; datapath captures read data.
- `win_idx`  out  4  window slot 0..8 (row-major, dy*3+dx) of the current read.
- `mac_go`  out  1  one-cycle strobe: all 9 taps delivered, datapath computes.
- `busy`  out  1  job in progress.
- `done_irq`  out  1  level; equals the sticky DONE flag.

## Operation
Registers (unlisted addresses read 0, writes ignored):
- 0 CTRL: bit0 START (write-1 pulse); bit1 CLR_DONE (write-1 pulse).
- 1 WIDTH, 2 HEIGHT, 3 SRC_BASE, 4 DST_BASE: read/write.
- 5 STATUS (read-only): bit0 busy, bit1 done, bit2 err.

Register write rules:
- Writes to addresses 1–4 while `busy` are ignored; the configuration is locked.
- START while `busy` is ignored.
- START is accepted only in IDLE or DONE. It clears done and err.
- CLR_DONE clears done; it returns the FSM from DONE to IDLE.

FSM states:
- IDLE: waits for START.
- CHECK (1 cycle): if WIDTH<3 or HEIGHT<3, sets err and goes to DONE. Otherwise row=1, col=1, tap=0, then FETCH.
- FETCH: read at SRC_BASE + (row+dy-1)*WIDTH + (col+dx-1), with dy=tap/3 and dx=tap%3.
  - On `mem_ack`: if tap=8, go to MAC; otherwise tap+1.
- MAC (1 cycle): `mac_go`=1. Then WRITE.
- WRITE: write at DST_BASE + row*WIDTH + col; hold until `mem_ack`. Then NEXT.
- NEXT (1 cycle): tap=0.
  - If col=WIDTH-2: col=1, row+1.
  - If additionally row=HEIGHT-2: go to DONE; otherwise FETCH.
  - Otherwise col+1, then FETCH.
- DONE: done=1. Leaves on START (to CHECK) or CLR_DONE (to IDLE).

Output rules:
- `busy` is high in CHECK, FETCH, MAC, WRITE and NEXT.
- `win_idx` = tap in FETCH, 0 elsewhere.

Arithmetic and boundaries:
- Address arithmetic is unsigned, truncated to `AW` bits; wrap-around past 2^AW is silent.
- Border pixels are never read as centres and never written.
- Simultaneous START and CLR_DONE in one write: START wins.

Reset:
- All registers, counters and outputs go to 0 and the FSM to IDLE.
- Reset mid-job abandons the job; no further `mem_req` is issued.

## Timing
- START write in cycle N: CHECK in N+1, first `mem_req` in N+2.
- With `mem_ack` tied high: 9 FETCH + 1 MAC + 1 WRITE + 1 NEXT = 12 cycles per pixel.
- An interior job then takes 1 + 12*(W-2)*(H-2) cycles from CHECK to DONE.
- `done_irq` rises the cycle after the last NEXT.
- `mem_req`, `mem_wr` and `mem_addr` are registered outputs.
- `mem_ack` while `mem_req`=0 is ignored.
- The next access starts the cycle after an acknowledge; there is no back-to-back in the same cycle.

## Configuration
- `SHARP_PERF_CNT_EN` defined:
  - Adds register 6 CYCLES, a 32-bit counter cleared on START and incremented every cycle `busy`=1. It saturates at 0xFFFFFFFF and is read-only.
  - Adds register 7 STALLS, counting cycles where `mem_req`=1 and `mem_ack`=0. Same clear and saturation rules.
- Undefined: addresses 6 and 7 read 0 and the counters are not built.

## Test plan
- 4x4 image, SRC_BASE=0x100, DST_BASE=0x200, `mem_ack`=1: 36 reads; first tap at 0x100, centre tap of the first pixel at 0x105.
  - 4 writes, to 0x205, 0x206, 0x209 and 0x20A.
  - `done_irq` rises 49 cycles after CHECK.
- WIDTH=2, HEIGHT=5, START: no `mem_req`; STATUS=0b110 two cycles after the write.
- `mem_ack` delayed 3 cycles per access: `mem_addr` and `mem_wr` stay stable for the whole stall.
  - With the macro: STALLS = 3 × accesses.
- Write WIDTH=9 and START mid-job: both ignored; the job completes with the original geometry.
- Assert `reset` during WRITE: `mem_req` and `busy` drop asynchronously and all registers read 0.
  - A subsequent START runs a clean job.
- From DONE, CLR_DONE: `done_irq` falls next cycle and the FSM is in IDLE.
  - START and CLR_DONE together from DONE: the job restarts.
